bcd_ripple_counter: RTL
=======================

// Module: bcd_ripple_counter
// PURPOSE
//   Multi-digit BCD event counter. Sits downstream of the trigger/debounce stage and consumes its
//   inc_clk and ref_clk pulses plus the per-digit trigger levels (digit_sel).
//   On inc_clk, each selected digit is incremented. Carries ripple one digit per clock.
//   On ref_clk, the settled count is latched into bcd_out for the display/output driver.
// PARAMETERS
//   DIGITS     6   number of BCD digits; legal range 1..9 so worst-case ripple (DIGITS clk) < upstream 10-cycle window
//   CNT_WIDTH  4   bits per digit; fixed at 4, any other value is a configuration error
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   reset         in   1           asynchronous, active-high reset
//   inc_clk       in   1           1-cycle increment strobe from trigger stage
//   ref_clk       in   1           1-cycle refresh strobe from trigger stage
//   digit_sel     in   DIGITS      digits to increment on inc_clk (bit i = digit i, bit 0 = LSD)
//   clear         in   1           synchronous clear of count, pending carries and overflow
//   bcd_out       out  4*DIGITS    latched display value, digit i at [4i+3:4i]
//   busy          out  1           carry ripple in progress
//   overflow      out  1           sticky; set on carry out of the MSD
//   refresh_done  out  1           1-cycle pulse, the cycle after bcd_out updates
//   inc_dropped   out  1           1-cycle pulse, inc_clk arrived while busy and was ignored
// BEHAVIOUR
//   Reset values (asynchronous): all digits 0, pend 0, bcd_out 0, busy 0, overflow 0, refresh_done 0,
//   inc_dropped 0, ref_pending 0, state IDLE.
//   Priority: reset > clear > all else. clear zeroes digits, pend, overflow and ref_pending in one cycle.
//   clear does not touch bcd_out. State returns to IDLE.
//   Internal pend[DIGITS-1:0]: bit i means digit i needs +1.
//   State machine:
//     IDLE:  inc_clk=1 and digit_sel!=0 -> pend <= digit_sel; go to RIPPLE.
//            inc_clk=1 and digit_sel==0 -> no-op.
//     RIPPLE, each cycle, for every i with pend[i]:
//       digit[i] <= (digit[i]==9) ? 0 : digit[i]+1
//       next pend[i+1] = pend[i] & (digit[i]==9)
//       Bits not generated this cycle clear, so each digit changes by at most +1 per cycle.
//       Carry out of digit DIGITS-1 sets overflow; the count wraps (999999 -> 000000).
//       Exit to IDLE on the cycle that next pend==0.
//   busy = (state==RIPPLE), combinational from state.
//   Latency: single digit with no carry -> digit updated 1 clk after inc_clk, busy high 1 clk.
//     Full ripple over k digits -> k clk.
//   inc_clk while busy: ignored, count unchanged; inc_dropped pulses next cycle.
//   ref_clk with busy=0 (and no clear that cycle): bcd_out <= digits next edge; refresh_done pulses the cycle after.
//   ref_clk with busy=1: ref_pending set. The latch happens on the first edge where busy=0,
//     capturing the fully settled value.
//   Simultaneous inc_clk and ref_clk in IDLE: bcd_out captures the PRE-increment value.
//   Non-BCD digit values (10..15) cannot occur; the RTL asserts this in simulation.
// CONFIGURATION
//   COUNTER_SATURATE_EN defined:
//     Carry out of the MSD loads all digits with 9 that cycle instead of wrapping.
//     overflow is set and pend is cleared.
//     Further increments at 99..9 leave the count at 99..9.
//   Undefined: wrap-around behaviour as above.
// TESTING
//   1. Reset, inc_clk with digit_sel=000001 x3, then ref_clk -> bcd_out=000003, refresh_done 1 clk after latch.
//   2. Count=000999, inc_clk digit_sel=000001 -> busy high exactly 4 clk; ref_clk -> bcd_out=001000.
//   3. Count=999999, inc_clk sel=000001 -> wrap 000000, overflow=1 (sticky).
//      With COUNTER_SATURATE_EN -> 999999, overflow=1.
//   4. Count=000090, inc_clk sel=000011 -> 000101 after 2 clk; ref_clk at cycle 1 of ripple defers latch,
//      bcd_out=000101.
//   5. inc_clk during busy -> inc_dropped pulse, count unchanged; clear mid-ripple -> digits 0, busy 0 next clk.
//   6. Assert reset mid-ripple -> all outputs 0 immediately (asynchronous), no residual carry after release.

Source files
------------

// File: rtl/bcd_ripple_counter.sv
// Multi-digit BCD event counter: one-digit-per-clock carry ripple, deferred display latch.
// Define COUNTER_SATURATE_EN to stick at all-nines on MSD carry instead of wrapping.
module bcd_ripple_counter #(
   parameter int DIGITS    = 6,
   parameter int CNT_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        inc_clk,
   input  logic                        ref_clk,
   input  logic [DIGITS-1:0]           digit_sel,
   input  logic                        clear,
   output logic [CNT_WIDTH*DIGITS-1:0] bcd_out,
   output logic                        busy,
   output logic                        overflow,
   output logic                        refresh_done,
   output logic                        inc_dropped
);

   if (CNT_WIDTH != 4 || DIGITS < 1 || DIGITS > 9) begin : g_bad_cfg
      $error("bcd_ripple_counter: CNT_WIDTH must be 4 and DIGITS 1..9");
   end

   typedef enum logic {IDLE, RIPPLE} state_t;

   state_t                             state;
   logic [DIGITS-1:0][CNT_WIDTH-1:0]   dig, dig_nxt;
   logic [DIGITS-1:0]                  pend, pend_nxt;
   logic [DIGITS:0]                    gen;
   logic                               carry_out;
   logic                               ref_pending;
   logic                               latch_q;
   logic                               do_latch;

   assign busy = (state == RIPPLE);

   // gen[i+1] is the carry produced by digit i this cycle; gen[DIGITS] leaves the MSD.
   always_comb begin
      dig_nxt = dig;
      gen     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (pend[i]) begin
            if (dig[i] == CNT_WIDTH'(9)) begin
               dig_nxt[i] = '0;
               gen[i+1]   = 1'b1;
            end else begin
               dig_nxt[i] = dig[i] + CNT_WIDTH'(1);
            end
         end
      end
      carry_out = gen[DIGITS];
      pend_nxt  = gen[DIGITS-1:0];
`ifdef COUNTER_SATURATE_EN
      if (carry_out) begin
         for (int i = 0; i < DIGITS; i++) dig_nxt[i] = CNT_WIDTH'(9);
         pend_nxt = '0;
      end
`endif
   end

   // A refresh requested during a ripple waits here until the count settles.
   assign do_latch = (ref_clk | ref_pending) & (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         dig          <= '0;
         pend         <= '0;
         bcd_out      <= '0;
         overflow     <= 1'b0;
         refresh_done <= 1'b0;
         inc_dropped  <= 1'b0;
         ref_pending  <= 1'b0;
         latch_q      <= 1'b0;
      end else begin
         refresh_done <= latch_q;
         latch_q      <= 1'b0;
         inc_dropped  <= 1'b0;
         if (clear) begin
            state       <= IDLE;
            dig         <= '0;
            pend        <= '0;
            overflow    <= 1'b0;
            ref_pending <= 1'b0;
         end else begin
            if (do_latch) begin
               bcd_out     <= dig;
               latch_q     <= 1'b1;
               ref_pending <= 1'b0;
            end else if (ref_clk) begin
               ref_pending <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (inc_clk && digit_sel != '0) begin
                     pend  <= digit_sel;
                     state <= RIPPLE;
                  end
               end
               RIPPLE: begin
                  dig         <= dig_nxt;
                  pend        <= pend_nxt;
                  inc_dropped <= inc_clk;
                  if (carry_out) overflow <= 1'b1;
                  if (pend_nxt == '0) state <= IDLE;
               end
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd_chk
      a_bcd_legal: assert property (@(posedge clk) disable iff (reset) dig[gi] <= CNT_WIDTH'(9));
   end

endmodule
